// File: rtl/turn_signal_fsm_if.sv
// Switch inputs and tail-light state outputs of the turn/hazard controller.
// The master drives the raw switches; the slave (controller) drives state/tick/phase.
interface turn_signal_fsm_if;
  logic [1:0] SW;
  logic       HAZ;
  logic [2:0] CurrentState;
  logic       tick;
  logic [1:0] phase;

  modport master (
    output SW,
    output HAZ,
    input  CurrentState,
    input  tick,
    input  phase
  );

  modport slave (
    input  SW,
    input  HAZ,
    output CurrentState,
    output tick,
    output phase
  );
endinterface

// File: rtl/turn_signal_fsm.sv
// Turn/hazard input controller: synchronise and debounce switches, generate the
// flash step tick, and sequence 4-step turn sweeps that complete unless hazards preempt.
module turn_signal_fsm #(
  parameter int unsigned TICK_DIV   = 12_500_000,
  parameter int unsigned DEB_CYCLES = 500_000,
  parameter int unsigned DIV_W      = 24
) (
  input  logic              clk,
  input  logic              reset,
  turn_signal_fsm_if.slave  bus
);

  localparam logic [2:0] ST_IDLE  = 3'b000;
  localparam logic [2:0] ST_HAZ   = 3'b001;
  localparam logic [2:0] ST_LEFT  = 3'b010;
  localparam logic [2:0] ST_RIGHT = 3'b011;

  localparam logic [DIV_W-1:0] PRE_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0] DEB_LAST = DIV_W'(DEB_CYCLES - 1);

  // Bit 2 = HAZ, bits 1:0 = SW
  logic [2:0]       r_sync1;
  logic [2:0]       r_sync2;
  logic [2:0]       r_deb;
  logic [DIV_W-1:0] r_deb_cnt [3];

  logic [DIV_W-1:0] r_pre;
  logic             r_tick;
  logic [2:0]       r_state;
  logic [1:0]       r_phase;

  logic             w_haz;
  logic             w_left;
  logic             w_right;
  logic [2:0]       w_next_state;
  logic [1:0]       w_next_phase;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {bus.HAZ, bus.SW};
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_deb <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        r_deb_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (r_deb_cnt[i] == DEB_LAST) begin
          r_deb[i]     <= r_sync2[i];
          r_deb_cnt[i] <= '0;
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pre  <= '0;
      r_tick <= 1'b0;
    end else if (r_pre == PRE_LAST) begin
      r_pre  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_pre  <= r_pre + 1'b1;
      r_tick <= 1'b0;
    end
  end

  assign w_haz   = r_deb[2] | (r_deb[1:0] == 2'b11);
  assign w_left  = (r_deb[1:0] == 2'b01);
  assign w_right = (r_deb[1:0] == 2'b10);

  always_comb begin
    w_next_state = ST_IDLE;
    w_next_phase = '0;
    case (r_state)
      ST_IDLE, ST_HAZ: begin
        if (w_haz)        w_next_state = ST_HAZ;
        else if (w_left)  w_next_state = ST_LEFT;
        else if (w_right) w_next_state = ST_RIGHT;
        else              w_next_state = ST_IDLE;
      end
      ST_LEFT, ST_RIGHT: begin
        if (w_haz) begin
          w_next_state = ST_HAZ;
        end else if (r_phase != 2'd3) begin
          w_next_state = r_state;
          w_next_phase = r_phase + 2'd1;
        end else if (w_left) begin
          w_next_state = ST_LEFT;
        end else if (w_right) begin
          w_next_state = ST_RIGHT;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_phase = '0;
      end
    endcase
  end

  // Illegal codes recover on any edge; legal states only advance on a tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_phase <= '0;
    end else if (r_tick || (r_state > ST_RIGHT)) begin
      r_state <= w_next_state;
      r_phase <= w_next_phase;
    end
  end

  assign bus.CurrentState = r_state;
  assign bus.tick         = r_tick;
  assign bus.phase        = r_phase;

endmodule

// File: tb/tb_turn_signal_fsm.sv
// Directed and randomized bench for turn_signal_fsm against a sample-history reference model.
module tb_turn_signal_fsm;

  localparam int TD = 4;
  localparam int DB = 3;

  localparam int M_IDLE  = 0;
  localparam int M_HAZ   = 1;
  localparam int M_LEFT  = 2;
  localparam int M_RIGHT = 3;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  turn_signal_fsm_if bus ();

  turn_signal_fsm #(
    .TICK_DIV   (TD),
    .DEB_CYCLES (DB),
    .DIV_W      (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int         vecs = 0;
  int         errs = 0;

  int         n;
  logic [2:0] raw_at [0:8191];
  logic [2:0] m_deb;
  int         m_mode;
  int         m_ph;
  logic       m_tick;

  task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
    vecs++;
    assert (got === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, got, exp, n);
    end
  endtask

  task automatic check_all();
    chk("state", bus.CurrentState, 3'(m_mode));
    chk("phase", 3'(bus.phase), 3'(m_ph));
    chk("tick", 3'(bus.tick), 3'(m_tick));
  endtask

  function automatic logic [2:0] synced_before(input int k);
    // Value the synchroniser presents to the debouncer just before edge k.
    if (k >= 3) return raw_at[k-2];
    return 3'b000;
  endfunction

  task automatic model_reset();
    n      = 0;
    m_deb  = '0;
    m_mode = M_IDLE;
    m_ph   = 0;
    m_tick = 1'b0;
  endtask

  task automatic model_edge();
    logic       haz, left, right;
    logic [2:0] s;
    logic [2:0] nd;
    bit         all_diff;
    int         want;
    n++;
    raw_at[n] = {bus.HAZ, bus.SW};
    if (m_tick) begin
      haz   = m_deb[2] | (m_deb[1:0] == 2'b11);
      left  = (m_deb[1:0] == 2'b01);
      right = (m_deb[1:0] == 2'b10);
      want  = haz ? M_HAZ : left ? M_LEFT : right ? M_RIGHT : M_IDLE;
      if (m_mode == M_IDLE || m_mode == M_HAZ) begin
        m_mode = want;
        m_ph   = 0;
      end else if (haz) begin
        m_mode = M_HAZ;
        m_ph   = 0;
      end else if (m_ph < 3) begin
        m_ph = m_ph + 1;
      end else begin
        m_mode = want;
        m_ph   = 0;
      end
    end
    nd = m_deb;
    for (int b = 0; b < 3; b++) begin
      if (n >= DB) begin
        all_diff = 1'b1;
        for (int j = 0; j < DB; j++) begin
          s = synced_before(n - j);
          if (s[b] == m_deb[b]) all_diff = 1'b0;
        end
        if (all_diff) nd[b] = ~m_deb[b];
      end
    end
    m_deb  = nd;
    m_tick = ((n % TD) == 0);
  endtask

  task automatic step(input logic [1:0] sw, input logic haz);
    bus.SW  = sw;
    bus.HAZ = haz;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic run_until(input string tag, input logic [1:0] sw, input logic haz,
                           input logic [2:0] st, input int ph, input int bound);
    bit met;
    met = 1'b0;
    for (int i = 0; i < bound && !met; i++) begin
      step(sw, haz);
      if (bus.CurrentState === st && (ph < 0 || 32'(bus.phase) == ph)) met = 1'b1;
    end
    vecs++;
    assert (met)
    else begin
      errs++;
      $error("FAIL %s: observed state %0h phase %0d, required state %0h phase %0d within %0d cycles",
             tag, bus.CurrentState, bus.phase, st, ph, bound);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    chk("rst_state", bus.CurrentState, 3'b000);
    chk("rst_phase", 3'(bus.phase), 3'b000);
    chk("rst_tick", 3'(bus.tick), 3'b000);
  endtask

  initial begin
    reset   = 1'b1;
    bus.SW  = 2'b00;
    bus.HAZ = 1'b0;
    model_reset();

    // 1: idle after reset, tick every TD cycles
    do_reset();
    repeat (13) step(2'b00, 1'b0);

    // 2: short glitch rejected, held request accepted
    step(2'b01, 1'b0);
    step(2'b01, 1'b0);
    repeat (10) step(2'b00, 1'b0);
    chk("glitch_idle", bus.CurrentState, 3'b000);
    run_until("left_enter", 2'b01, 1'b0, 3'b010, 0, 20);
    chk("left_enter_ph", 3'(bus.phase), 3'b000);

    // 3: release mid-sweep, sweep completes then idle
    run_until("left_ph1", 2'b01, 1'b0, 3'b010, 1, 12);
    run_until("sweep_done", 2'b00, 1'b0, 3'b000, 0, 30);

    // 4: hazard preempts, then right request after hazard drops
    run_until("left_again", 2'b01, 1'b0, 3'b010, 1, 30);
    run_until("haz_preempt", 2'b01, 1'b1, 3'b001, 0, 20);
    run_until("haz_to_right", 2'b10, 1'b0, 3'b011, 0, 20);

    // 5: both switches mean hazard; opposite request switches after phase 3
    run_until("sw11_haz", 2'b11, 1'b0, 3'b001, 0, 20);
    run_until("left_ph2", 2'b01, 1'b0, 3'b010, 2, 30);
    run_until("swap_right", 2'b10, 1'b0, 3'b011, -1, 20);
    chk("swap_right_ph", 3'(bus.phase), 3'b000);

    // 6: asynchronous reset mid-sweep
    run_until("left_ph2_b", 2'b01, 1'b0, 3'b010, 2, 40);
    #2;
    reset = 1'b1;
    #1;
    chk("async_state", bus.CurrentState, 3'b000);
    chk("async_phase", 3'(bus.phase), 3'b000);
    chk("async_tick", 3'(bus.tick), 3'b000);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    check_all();

    // randomized segments of held inputs, including sub-debounce glitches
    for (int seg = 0; seg < 200; seg++) begin
      logic [1:0] sw;
      logic       hz;
      int         len;
      sw  = 2'($urandom_range(0, 3));
      hz  = ($urandom_range(0, 4) == 0);
      len = int'($urandom_range(1, 14));
      repeat (len) step(sw, hz);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
